// File: rtl/iq_accumulator.sv
// iq_accumulator: phase-aligned I/Q demodulating accumulator with saturation
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   EN                       demodulation enable; low discards everything in flight
//   PHASE, ADC_VALID         sample phase index and its valid strobe
//   ADC_DATA, SIN_REF, COS_REF  signed sample and reference values
//   I_OUT, Q_OUT, OVERFLOW   per-period result, held until the next OUT_VALID
//   OUT_VALID                one-cycle result strobe
//   SYNC_ERR                 sticky phase discontinuity flag, cleared by EN low
//   BUSY                     high while accumulating a period
module iq_accumulator #(
  parameter int PERIOD = 80,
  parameter int ADC_W = 12,
  parameter int REF_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [7:0]              PHASE,
  input  logic                    ADC_VALID,
  input  logic signed [ADC_W-1:0] ADC_DATA,
  input  logic signed [REF_W-1:0] SIN_REF,
  input  logic signed [REF_W-1:0] COS_REF,
  output logic signed [ACC_W-1:0] I_OUT,
  output logic signed [ACC_W-1:0] Q_OUT,
  output logic                    OUT_VALID,
  output logic                    OVERFLOW,
  output logic                    SYNC_ERR,
  output logic                    BUSY
);
  localparam int PW = ADC_W + REF_W;
  typedef enum logic [1:0] {IDLE, ALIGN, ACCUM} state_t;
  state_t st, st_n;
  logic s1_v, end_q, end_n, ovf, ovf_n, ovf_end, ovf_end_n, err_n;
  logic hit, load, keep, last, sat_i, sat_q;
  logic [7:0] s1_ph, exp_ph, exp_n;
  logic signed [PW-1:0] p_i, p_q;
  logic signed [ACC_W-1:0] acc_i, acc_q, acc_i_n, acc_q_n, sum_i, sum_q;
  // returns {saturated, clamped sum}; a one-bit guard detects signed overflow
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a, input logic signed [PW-1:0] b);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W+1-PW){b[PW-1]}}, b});
    return (s[ACC_W] != s[ACC_W-1]) ? {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : {1'b0, s[ACC_W-1:0]};
  endfunction
  assign hit = (st == ACCUM) && (s1_ph == exp_ph);
  assign load = s1_ph == 8'd0;
  assign keep = hit || load;
  assign last = s1_ph == 8'(PERIOD - 1);
  // phase 0 always restarts from zero, which gives back-to-back periods and realignment
  assign {sat_i, sum_i} = sat_add(load ? '0 : acc_i, p_i);
  assign {sat_q, sum_q} = sat_add(load ? '0 : acc_q, p_q);
  assign BUSY = st == ACCUM;
  always_comb begin
    st_n = st;
    acc_i_n = acc_i;
    acc_q_n = acc_q;
    ovf_n = ovf;
    exp_n = exp_ph;
    err_n = SYNC_ERR;
    end_n = 1'b0;
    ovf_end_n = ovf_end;
    if (!EN) begin
      st_n = IDLE;
      acc_i_n = '0;
      acc_q_n = '0;
      ovf_n = 1'b0;
      exp_n = '0;
      err_n = 1'b0;
    end else if (st == IDLE) begin
      st_n = ALIGN;
    end else if (s1_v) begin
      // a mismatching sample is re-judged as an align candidate: phase 0 reloads at once
      err_n = SYNC_ERR || ((st == ACCUM) && !hit);
      st_n = keep ? ACCUM : ALIGN;
      acc_i_n = keep ? sum_i : '0;
      acc_q_n = keep ? sum_q : '0;
      ovf_n = keep && (sat_i || sat_q || (ovf && !load));
      exp_n = !keep ? '0 : last ? 8'd0 : s1_ph + 8'd1;
      end_n = keep && last;
      ovf_end_n = ovf_n;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st <= IDLE;
      s1_v <= 1'b0;
      s1_ph <= '0;
      p_i <= '0;
      p_q <= '0;
      acc_i <= '0;
      acc_q <= '0;
      ovf <= 1'b0;
      exp_ph <= '0;
      end_q <= 1'b0;
      ovf_end <= 1'b0;
      SYNC_ERR <= 1'b0;
      OUT_VALID <= 1'b0;
      I_OUT <= '0;
      Q_OUT <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      st <= st_n;
      s1_v <= ADC_VALID && EN;
      s1_ph <= PHASE;
      p_i <= PW'(ADC_DATA) * PW'(SIN_REF);
      p_q <= PW'(ADC_DATA) * PW'(COS_REF);
      acc_i <= acc_i_n;
      acc_q <= acc_q_n;
      ovf <= ovf_n;
      exp_ph <= exp_n;
      end_q <= end_n && EN;
      ovf_end <= ovf_end_n;
      SYNC_ERR <= err_n;
      OUT_VALID <= end_q && EN;
      if (end_q && EN) begin
        I_OUT <= acc_i;
        Q_OUT <= acc_q;
        OVERFLOW <= ovf_end;
      end
    end
  end
endmodule

// File: tb/tb_iq_accumulator.sv
// tb_iq_accumulator: directed self-checking bench for iq_accumulator
module tb_iq_accumulator;
  logic CLK = 0, RST = 0, EN = 0, ADC_VALID = 0;
  logic [7:0] PHASE = 0;
  logic signed [11:0] ADC_DATA = 0;
  logic signed [7:0] SIN_REF = 0, COS_REF = 0;
  logic signed [31:0] I_OUT, Q_OUT;
  logic signed [19:0] I2, Q2;
  logic OUT_VALID, OVERFLOW, SYNC_ERR, BUSY, ov2, ovf2, se2, busy2;
  int checks = 0, errors = 0, cyc = 0, ov_cnt = 0, ov_last = 0, ov_prev = 0, end_cyc = 0, base = 0;
  iq_accumulator dut (.CLK(CLK), .RST(RST), .EN(EN), .PHASE(PHASE), .ADC_VALID(ADC_VALID),
    .ADC_DATA(ADC_DATA), .SIN_REF(SIN_REF), .COS_REF(COS_REF), .I_OUT(I_OUT), .Q_OUT(Q_OUT),
    .OUT_VALID(OUT_VALID), .OVERFLOW(OVERFLOW), .SYNC_ERR(SYNC_ERR), .BUSY(BUSY));
  iq_accumulator #(.ACC_W(20)) dut2 (.CLK(CLK), .RST(RST), .EN(EN), .PHASE(PHASE), .ADC_VALID(ADC_VALID),
    .ADC_DATA(ADC_DATA), .SIN_REF(SIN_REF), .COS_REF(COS_REF), .I_OUT(I2), .Q_OUT(Q2),
    .OUT_VALID(ov2), .OVERFLOW(ovf2), .SYNC_ERR(se2), .BUSY(busy2));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (OUT_VALID) begin
    ov_cnt++;
    ov_prev = ov_last;
    ov_last = cyc;
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic send(input int p, input int d, input int s, input int c);
    PHASE = 8'(p);
    ADC_DATA = 12'(d);
    SIN_REF = 8'(s);
    COS_REF = 8'(c);
    ADC_VALID = 1;
    if (p == 79) end_cyc = cyc;
    idle(1);
    ADC_VALID = 0;
  endtask
  task automatic run(input int lo, input int hi, input int d, input int s, input int c, input bit gap);
    for (int p = lo; p <= hi; p++) begin
      send(p, d, s, c);
      if (gap) idle(1);
    end
  endtask
  task automatic restart();
    EN = 0;
    idle(1);
    EN = 1;
    idle(1);
    base = ov_cnt;
  endtask
  initial begin
    idle(2);
    chk("rst_i", I_OUT, 0);
    chk("rst_q", Q_OUT, 0);
    chk("rst_ov", OUT_VALID, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1;
    idle(1);
    restart();
    run(0, 79, 100, 64, 0, 0);
    idle(5);
    chk("basic_n", ov_cnt - base, 1);
    chk("basic_lat", ov_last - end_cyc, 3);
    chk("basic_i", I_OUT, 512000);
    chk("basic_q", Q_OUT, 0);
    chk("basic_ovf", OVERFLOW, 0);
    chk("basic_busy", BUSY, 1);
    restart();
    run(37, 79, 10, 5, 3, 0);
    idle(4);
    chk("align_none", ov_cnt - base, 0);
    run(0, 79, 10, 5, 3, 0);
    idle(5);
    chk("align_n", ov_cnt - base, 1);
    chk("align_i", I_OUT, 4000);
    chk("align_q", Q_OUT, 2400);
    chk("align_se", SYNC_ERR, 0);
    restart();
    for (int k = 0; k < 3; k++) run(0, 79, -2048, -128, 127, 0);
    idle(5);
    chk("b2b_n", ov_cnt - base, 3);
    chk("b2b_space", ov_last - ov_prev, 80);
    chk("b2b_i", I_OUT, 20971520);
    chk("b2b_q", Q_OUT, -20807680);
    restart();
    run(0, 40, 3, 7, -2, 0);
    run(42, 79, 3, 7, -2, 0);
    idle(4);
    chk("skip_se", SYNC_ERR, 1);
    chk("skip_none", ov_cnt - base, 0);
    run(0, 79, 3, 7, -2, 0);
    idle(5);
    chk("skip_n", ov_cnt - base, 1);
    chk("skip_i", I_OUT, 1680);
    chk("skip_q", Q_OUT, -480);
    chk("skip_se_hold", SYNC_ERR, 1);
    EN = 0;
    idle(1);
    chk("skip_se_clr", SYNC_ERR, 0);
    restart();
    run(0, 79, 100, 64, 0, 1);
    idle(5);
    chk("gap_n", ov_cnt - base, 1);
    chk("gap_i", I_OUT, 512000);
    restart();
    run(0, 79, 2047, 127, 0, 0);
    idle(5);
    chk("sat_i20", I2, 524287);
    chk("sat_ovf20", ovf2, 1);
    chk("sat_i32", I_OUT, 20797520);
    chk("sat_ovf32", OVERFLOW, 0);
    restart();
    run(0, 5, 1, 1, 1, 0);
    send(90, 1, 1, 1);
    idle(3);
    chk("range_se", SYNC_ERR, 1);
    chk("range_busy", BUSY, 0);
    restart();
    run(0, 79, 1, 1, 1, 0);
    run(0, 49, 5, 5, 5, 0);
    EN = 0;
    send(50, 5, 5, 5);
    idle(5);
    chk("en_none", ov_cnt - base, 1);
    chk("en_i", I_OUT, 80);
    chk("en_q", Q_OUT, 80);
    chk("en_busy", BUSY, 0);
    restart();
    run(0, 49, 5, 5, 5, 0);
    RST = 0;
    send(50, 5, 5, 5);
    idle(3);
    chk("rstm_none", ov_cnt - base, 0);
    chk("rstm_i", I_OUT, 0);
    chk("rstm_q", Q_OUT, 0);
    chk("rstm_busy", BUSY, 0);
    RST = 1;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
